hex_display: RTL and testbench

//   Memory-mapped 4-digit 7-segment hex display peripheral for the SoC data bus.
//   - Holds one 32-bit display register, writable by byte, half or word.
//   - Reads the register back with 1-cycle latency.
//   - Time-multiplexes the low 16 bits as 4 hex digits onto shared segment lines.
//   - The top level inverts the anodes onto the board's active-low digit enables.

---
 rtl/hex_display_pkg.sv | 28 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/hex_display.sv | 115 +++++++++++
 tb/tb_hex_display.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants and helpers for the hex display peripheral
package hex_display_pkg;

  // Bus access window encodings
  localparam logic [1:0] WIN_BYTE = 2'b00;
  localparam logic [1:0] WIN_HALF = 2'b01;
  localparam logic [1:0] WIN_WORD = 2'b10;
  localparam logic [1:0] WIN_NONE = 2'b11;

  // Seven-segment font, {A,B,C,D,E,F,G}; element i is the glyph for nibble i
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,  // F E d C
    7'h1F, 7'h77, 7'h7B, 7'h7F,  // b A 9 8
    7'h70, 7'h5F, 7'h5B, 7'h33,  // 7 6 5 4
    7'h79, 7'h6D, 7'h30, 7'h7E   // 3 2 1 0
  };

  // Index of the most significant non-zero nibble; 0 when the value is zero
  function automatic logic [1:0] msd_index(input logic [15:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[7:4] != 4'h0)   idx = 2'd1;
    if (v[11:8] != 4'h0)  idx = 2'd2;
    if (v[15:12] != 4'h0) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to seven-segment glyph lookup
module hex_to_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_FONT[nibble];

endmodule

// File: rtl/hex_display.sv
// rtl/hex_display.sv - memory-mapped 4-digit hex display (optional HEX_DISPLAY_LZB_EN blanking)
module hex_display
  import hex_display_pkg::*;
#(
  parameter int SCAN_BITS = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  data_addr,
  input  logic [31:0] data_in,
  input  logic        write_enable,
  input  logic [1:0]  window_size,
  output logic [31:0] data_out,
  output logic [3:0]  anodes,
  output logic [6:0]  segments
);

  logic [31:0]          disp_q, disp_d;
  logic [SCAN_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]          data_out_q, data_out_d;
  logic [3:0]           anodes_q, anodes_d;
  logic [6:0]           segments_q, segments_d;

  logic [3:0]  byte_mask;
  logic [31:0] wdata;
  logic [1:0]  digit;
  logic [3:0]  nibble;
  logic [6:0]  glyph;

  // Replicate the right-aligned write data across all lanes and pick lanes by window
  always_comb begin
    byte_mask = 4'b0000;
    wdata     = data_in;
    case (window_size)
      WIN_BYTE: begin
        byte_mask = 4'b0001 << data_addr;
        wdata     = {4{data_in[7:0]}};
      end
      WIN_HALF: begin
        byte_mask = data_addr[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{data_in[15:0]}};
      end
      WIN_WORD: begin
        byte_mask = 4'b1111;
        wdata     = data_in;
      end
      default: begin
        byte_mask = 4'b0000;
        wdata     = data_in;
      end
    endcase
    if (!write_enable) begin
      byte_mask = 4'b0000;
    end
  end

  // Merge selected lanes into the display register; other bytes hold
  always_comb begin
    disp_d = disp_q;
    for (int i = 0; i < 4; i++) begin
      if (byte_mask[i]) begin
        disp_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Free-running scan counter; top two bits select the active digit
  always_comb begin
    cnt_d = cnt_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
    digit = cnt_q[SCAN_BITS-1 -: 2];
  end

  assign nibble = disp_q[4*digit +: 4];

  hex_to_seg7 u_font (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Next-state of the registered read port and digit drive
  always_comb begin
    data_out_d = disp_q;
    anodes_d   = 4'b0001 << digit;
    segments_d = glyph;
`ifdef HEX_DISPLAY_LZB_EN
    // Leading zeros go dark; digit 0 always stays lit so zero shows "0"
    if (digit > msd_index(disp_q[15:0])) begin
      anodes_d   = 4'b0000;
      segments_d = 7'h00;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= 32'h0;
      cnt_q      <= '0;
      data_out_q <= 32'h0;
      anodes_q   <= 4'b0000;
      segments_q <= 7'h00;
    end else begin
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
    end
  end

  assign data_out = data_out_q;
  assign anodes   = anodes_q;
  assign segments = segments_q;

endmodule

// File: tb/tb_hex_display.sv
// tb/tb_hex_display.sv - scoreboard bench for hex_display against a reference model
module tb_hex_display;

  localparam int SB = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  data_addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic [1:0]  window_size;
  logic [31:0] data_out;
  logic [3:0]  anodes;
  logic [6:0]  segments;

  int vectors;
  int miscompares;
  exp_t exp_q[$];

  logic [6:0] font [16];

  logic [31:0] m_reg;
  int          m_cnt;

  hex_display #(.SCAN_BITS(SB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_addr    (data_addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .window_size  (window_size),
    .data_out     (data_out),
    .anodes       (anodes),
    .segments     (segments)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    font[0]  = 7'h7E; font[1]  = 7'h30; font[2]  = 7'h6D; font[3]  = 7'h79;
    font[4]  = 7'h33; font[5]  = 7'h5B; font[6]  = 7'h5F; font[7]  = 7'h70;
    font[8]  = 7'h7F; font[9]  = 7'h7B; font[10] = 7'h77; font[11] = 7'h1F;
    font[12] = 7'h4E; font[13] = 7'h3D; font[14] = 7'h4F; font[15] = 7'h47;
  end

  // Reference model: predict what each edge will present, then apply the edge
  always @(posedge clk) begin
    exp_t e;
    int   d;
    int   top;
    if (!rst_n) begin
      m_reg = 32'h0;
      m_cnt = 0;
      e     = '0;
    end else begin
      d      = (m_cnt / (1 << (SB - 2))) % 4;
      e.data = m_reg;
      e.an   = 4'(1 << d);
      e.seg  = font[(m_reg >> (4 * d)) & 32'hF];
`ifdef HEX_DISPLAY_LZB_EN
      top = 0;
      for (int k = 0; k < 4; k++) begin
        if (((m_reg >> (4 * k)) & 32'hF) != 0) top = k;
      end
      if (d > top) begin
        e.an  = 4'b0000;
        e.seg = 7'h00;
      end
`else
      top = 3;
`endif
      if (write_enable) begin
        case (window_size)
          2'b00: m_reg[8 * data_addr +: 8] = data_in[7:0];
          2'b01: m_reg[16 * data_addr[1] +: 16] = data_in[15:0];
          2'b10: m_reg = data_in;
          default: ;
        endcase
      end
      m_cnt = (m_cnt + 1) % (1 << SB);
    end
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a word, anode set and glyph
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e.data || anodes !== e.an || segments !== e.seg) begin
          miscompares++;
          $display("FAIL scan_vec at %0t: got data=%08h an=%04b seg=%02h, want data=%08h an=%04b seg=%02h",
                   $time, data_out, anodes, segments, e.data, e.an, e.seg);
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic [1:0] ws, input logic [1:0] a, input logic [31:0] din);
    @(negedge clk);
    #1;
    write_enable = we;
    window_size  = ws;
    data_addr    = a;
    data_in      = din;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b11, 2'b00, 32'h0);
  endtask

  // Stimulus: directed cases from the feature list, then randomized traffic
  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    write_enable = 1'b0;
    window_size  = 2'b11;
    data_addr    = 2'b00;
    data_in      = 32'h0;
    m_reg        = 32'h0;
    m_cnt        = 0;

    idle(3);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(6);

    cyc(1'b1, 2'b10, 2'b11, 32'h1234ABCD);
    idle(20);
    cyc(1'b1, 2'b00, 2'b10, 32'hFFFFFFEF);
    idle(2);
    cyc(1'b1, 2'b01, 2'b01, 32'hAAAA5555);
    idle(2);
    cyc(1'b1, 2'b11, 2'b00, 32'hFFFFFFFF);
    idle(20);

    cyc(1'b1, 2'b10, 2'b00, 32'h00000007);
    idle(20);
    cyc(1'b1, 2'b10, 2'b00, 32'h00000000);
    idle(20);
    cyc(1'b1, 2'b10, 2'b00, 32'h00000A30);
    idle(20);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[15:0] = 16'(r[15:0] >> (4 * $urandom_range(1, 3)));
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), r);
    end

    // Asynchronous reset in the middle of a scan
    idle(5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (data_out !== 32'h0 || anodes !== 4'b0000 || segments !== 7'h00) begin
      miscompares++;
      $display("FAIL async_reset: got data=%08h an=%04b seg=%02h, want all zero",
               data_out, anodes, segments);
    end
    idle(2);
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
    end
    idle(20);

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
